spi_reg_master: RTL and testbench

Mode-0 SPI initiator (host end) for the raycaster's write-only register and vector SPI slave ports (csb/sclk/mosi).
- Replaces bit-banging those pins from logic-analyser lines.
- Takes one frame per valid/ready command (left-justified payload plus bit count) and serialises it MSB-first with programmable SCLK rate and an inter-frame gap.
- Sits in the user area between management-side glue and the raycaster's SPI inputs.

---
 rtl/spi_reg_master.sv | 164 ++++++++++++++++
 tb/tb_spi_reg_master.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_master.sv
// Mode-0 SPI initiator: serialises one left-justified frame per valid/ready command, MSB first.
// Define SPI_READBACK_EN to add i_miso capture into o_rdata.
module spi_reg_master #(
    parameter int unsigned MAX_BITS = 48,
    parameter int unsigned CLK_DIV  = 1
) (
    input  logic                          i_clk,
    input  logic                          i_reset_n,
    input  logic                          i_valid,
    output logic                          o_ready,
    input  logic [MAX_BITS-1:0]           i_data,
    input  logic [$clog2(MAX_BITS+1)-1:0] i_len,
    output logic                          o_busy,
    output logic                          o_done,
    output logic                          o_csb,
    output logic                          o_sclk,
`ifdef SPI_READBACK_EN
    input  logic                          i_miso,
    output logic [MAX_BITS-1:0]           o_rdata,
`endif
    output logic                          o_mosi
);

    localparam int unsigned LenW = $clog2(MAX_BITS + 1);
    localparam int unsigned DivW = $clog2(CLK_DIV + 1);
    localparam logic [DivW-1:0] DivReload = DivW'(CLK_DIV - 1);
    localparam logic [LenW-1:0] LenMax    = LenW'(MAX_BITS);

    typedef enum logic [2:0] {StIdle, StLead, StHigh, StLow, StGap} state_e;

    state_e                state_q, state_d;
    logic [DivW-1:0]       div_q, div_d;
    logic [LenW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [MAX_BITS-1:0]   shift_q, shift_d;
    logic                  csb_q, csb_d;
    logic                  sclk_q, sclk_d;
    logic                  mosi_q, mosi_d;
    logic                  ready_q, ready_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [LenW-1:0]       len_eff;
    logic                  accept;
    logic                  phase_end;

    assign accept    = i_valid && ready_q && (state_q == StIdle);
    assign len_eff   = (i_len > LenMax) ? LenMax : i_len;
    assign phase_end = (div_q == '0);

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        mosi_d    = mosi_q;
        done_d    = 1'b0;

        case (state_q)
            StIdle: begin
                if (accept) begin
                    shift_d = i_data;
                    if (len_eff == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d   = StLead;
                        bit_cnt_d = len_eff;
                        mosi_d    = i_data[MAX_BITS-1];
                    end
                end
            end
            StLead: begin
                if (phase_end) state_d = StHigh;
            end
            StHigh: begin
                if (phase_end) begin
                    state_d   = StLow;
                    bit_cnt_d = bit_cnt_q - 1'b1;
                    shift_d   = shift_q << 1;
                    // Last bit: park MOSI low instead of exposing payload padding.
                    mosi_d    = (bit_cnt_q == LenW'(1)) ? 1'b0 : shift_d[MAX_BITS-1];
                end
            end
            StLow: begin
                if (phase_end) state_d = (bit_cnt_q == '0) ? StGap : StHigh;
            end
            StGap: begin
                if (phase_end) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (state_d != state_q) begin
            div_d = DivReload;
        end else if (div_q != '0) begin
            div_d = div_q - 1'b1;
        end else begin
            div_d = div_q;
        end

        csb_d   = !(state_d inside {StLead, StHigh, StLow});
        sclk_d  = (state_d == StHigh);
        ready_d = (state_d == StIdle);
        busy_d  = !ready_d;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q   <= StIdle;
            div_q     <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            csb_q     <= 1'b1;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            csb_q     <= csb_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign o_ready = ready_q;
    assign o_busy  = busy_q;
    assign o_done  = done_q;
    assign o_csb   = csb_q;
    assign o_sclk  = sclk_q;
    assign o_mosi  = mosi_q;

`ifdef SPI_READBACK_EN
    logic [MAX_BITS-1:0] rdata_q, rdata_d;

    // Sample on the same edge that raises SCLK, shifting in from bit 0.
    always_comb begin
        rdata_d = rdata_q;
        if (accept) begin
            rdata_d = '0;
        end else if (state_d == StHigh && state_q != StHigh) begin
            rdata_d = {rdata_q[MAX_BITS-2:0], i_miso};
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign o_rdata = rdata_q;
`endif

endmodule

// File: tb/tb_spi_reg_master.sv
// Directed bench for spi_reg_master: two instances (CLK_DIV=1 and 3) behind a select mux.
// Define SPI_READBACK_EN to include the MISO capture test.
module tb_spi_reg_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid;
    logic        sel;
    logic [47:0] data;
    logic [5:0]  len;

    logic valid1, valid3;
    logic ready1, ready3, busy1, busy3, done1, done3;
    logic csb1, csb3, sclk1, sclk3, mosi1, mosi3;
    logic ready, busy, done, csb, sclk, mosi;
`ifdef SPI_READBACK_EN
    logic        miso;
    logic [47:0] rdata1, rdata3, rdata;
`endif

    always #5 clk = ~clk;

    assign valid1 = valid & ~sel;
    assign valid3 = valid & sel;
    assign ready  = sel ? ready3 : ready1;
    assign busy   = sel ? busy3  : busy1;
    assign done   = sel ? done3  : done1;
    assign csb    = sel ? csb3   : csb1;
    assign sclk   = sel ? sclk3  : sclk1;
    assign mosi   = sel ? mosi3  : mosi1;
`ifdef SPI_READBACK_EN
    assign rdata  = sel ? rdata3 : rdata1;
`endif

    spi_reg_master #(.MAX_BITS(48), .CLK_DIV(1)) u_dut_d1 (
        .i_clk    (clk),
        .i_reset_n(rst_n),
        .i_valid  (valid1),
        .o_ready  (ready1),
        .i_data   (data),
        .i_len    (len),
        .o_busy   (busy1),
        .o_done   (done1),
        .o_csb    (csb1),
        .o_sclk   (sclk1),
`ifdef SPI_READBACK_EN
        .i_miso   (miso),
        .o_rdata  (rdata1),
`endif
        .o_mosi   (mosi1)
    );

    spi_reg_master #(.MAX_BITS(48), .CLK_DIV(3)) u_dut_d3 (
        .i_clk    (clk),
        .i_reset_n(rst_n),
        .i_valid  (valid3),
        .o_ready  (ready3),
        .i_data   (data),
        .i_len    (len),
        .o_busy   (busy3),
        .o_done   (done3),
        .o_csb    (csb3),
        .o_sclk   (sclk3),
`ifdef SPI_READBACK_EN
        .i_miso   (miso),
        .o_rdata  (rdata3),
`endif
        .o_mosi   (mosi3)
    );

    int n_checks = 0;
    int n_fail   = 0;

    int          cyc, n_rise, n_high, n_low, first_low, last_low;
    int          n_done, done_cyc, hi_run, gap_hi;
    logic [63:0] rise_mosi;
    logic [63:0] miso_bits = '0;
    logic        prev_sclk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_stats();
        cyc       = 0;
        n_rise    = 0;
        n_high    = 0;
        n_low     = 0;
        first_low = -1;
        last_low  = -1;
        n_done    = 0;
        done_cyc  = -1;
        hi_run    = 0;
        gap_hi    = -1;
        rise_mosi = '0;
        prev_sclk = sclk;
`ifdef SPI_READBACK_EN
        miso = miso_bits[0];
`endif
    endtask

    // One clock; outputs sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (sclk && !prev_sclk) begin
            if (n_rise < 64) rise_mosi[n_rise] = mosi;
            n_rise++;
        end
        prev_sclk = sclk;
        if (sclk) n_high++;
        if (!csb) begin
            n_low++;
            if (first_low < 0) first_low = cyc;
            last_low = cyc;
            if (hi_run > 0) gap_hi = hi_run;
            hi_run = 0;
        end else if (first_low >= 0) begin
            hi_run++;
        end
        if (done) begin
            n_done++;
            done_cyc = cyc;
        end
`ifdef SPI_READBACK_EN
        miso = (n_rise < 64) ? miso_bits[n_rise] : 1'b0;
`endif
    endtask

    task automatic start(input logic [47:0] d, input logic [5:0] l, input bit hold);
        check_eq("ready_before_accept", ready, 1);
        data  = d;
        len   = l;
        valid = 1'b1;
        clear_stats();
        tick();
        if (!hold) valid = 1'b0;
    endtask

    task automatic run_to_done(input int target, input int budget);
        while (n_done < target && cyc < budget) tick();
        check_eq("done_seen_within_budget", n_done, target);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        valid = 1'b0;
        sel   = 1'b0;
        data  = '0;
        len   = '0;
`ifdef SPI_READBACK_EN
        miso  = 1'b0;
`endif
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;
        check_eq("reset_csb", csb, 1);
        check_eq("reset_sclk", sclk, 0);
        check_eq("reset_mosi", mosi, 0);
        check_eq("reset_ready", ready, 1);
        check_eq("reset_busy", busy, 0);
        check_eq("reset_done", done, 0);
        check_eq("reset_csb_d3", csb3, 1);

        // 1: D=1, 4 bits 1010
        start(48'hA000_0000_0000, 6'd4, 1'b0);
        check_eq("t1_c1_csb", csb, 0);
        check_eq("t1_c1_ready", ready, 0);
        check_eq("t1_c1_busy", busy, 1);
        check_eq("t1_c1_mosi", mosi, 1);
        run_to_done(1, 50);
        check_eq("t1_done_cyc", done_cyc, 11);
        check_eq("t1_first_low", first_low, 1);
        check_eq("t1_last_low", last_low, 9);
        check_eq("t1_n_low", n_low, 9);
        check_eq("t1_rises", n_rise, 4);
        check_eq("t1_mosi_at_rises", rise_mosi[3:0], 4'h5);
        check_eq("t1_done_ready", ready, 1);
        check_eq("t1_done_busy", busy, 0);
        repeat (3) tick();
        check_eq("t1_single_done", n_done, 1);

        // 2: D=3, 48 bits, MSB and LSB set
        sel = 1'b1;
        start(48'h8000_0000_0001, 6'd48, 1'b0);
        run_to_done(1, 400);
        check_eq("t2_first_low", first_low, 1);
        check_eq("t2_n_low", n_low, 291);
        check_eq("t2_last_low", last_low, 291);
        check_eq("t2_rises", n_rise, 48);
        check_eq("t2_sclk_high_cycles", n_high, 144);
        check_eq("t2_mosi_at_rises", rise_mosi[47:0], 48'h8000_0000_0001);
        check_eq("t2_done_cyc", done_cyc, 295);
        sel = 1'b0;

        // 3: back-to-back, valid held
        start(48'hC000_0000_0000, 6'd2, 1'b1);
        run_to_done(1, 50);
        check_eq("t3_first_done_cyc", done_cyc, 7);
        data = 48'h4000_0000_0000;
        tick();
        valid = 1'b0;
        check_eq("t3_second_accepted", csb, 0);
        run_to_done(2, 60);
        check_eq("t3_second_done_cyc", done_cyc, 14);
        check_eq("t3_rises", n_rise, 4);
        check_eq("t3_mosi_at_rises", rise_mosi[3:0], 4'hB);
        check_eq("t3_csb_high_gap", gap_hi, 2);
        check_eq("t3_n_low", n_low, 10);

        // 4a: zero length
        start(48'hFFFF_FFFF_FFFF, 6'd0, 1'b0);
        check_eq("t4_zero_done_c1", done, 1);
        check_eq("t4_zero_ready_c1", ready, 1);
        repeat (4) tick();
        check_eq("t4_zero_n_low", n_low, 0);
        check_eq("t4_zero_rises", n_rise, 0);
        check_eq("t4_zero_n_done", n_done, 1);

        // 4b: length 60 clamps to 48
        start(48'hFFFF_FFFF_FFFF, 6'd60, 1'b0);
        run_to_done(1, 200);
        check_eq("t4_clamp_rises", n_rise, 48);
        check_eq("t4_clamp_n_low", n_low, 97);
        check_eq("t4_clamp_done_cyc", done_cyc, 99);

        // 5: reset after third rise
        start(48'hFFFF_FFFF_FFFF, 6'd8, 1'b0);
        while (n_rise < 3 && cyc < 100) tick();
        check_eq("t5_reached_third_rise", n_rise, 3);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_eq("t5_rst_csb", csb, 1);
        check_eq("t5_rst_sclk", sclk, 0);
        check_eq("t5_rst_mosi", mosi, 0);
        check_eq("t5_rst_ready", ready, 1);
        check_eq("t5_rst_busy", busy, 0);
        check_eq("t5_rst_done", done, 0);
        repeat (20) tick();
        check_eq("t5_no_done_after_abort", n_done, 0);
        check_eq("t5_no_rise_after_abort", n_rise, 3);
        start(48'hA000_0000_0000, 6'd4, 1'b0);
        run_to_done(1, 50);
        check_eq("t5_recover_done_cyc", done_cyc, 11);
        check_eq("t5_recover_rises", n_rise, 4);
        check_eq("t5_recover_mosi", rise_mosi[3:0], 4'h5);

`ifdef SPI_READBACK_EN
        // 6: MISO 1,1,0,0,1,0,1,0 at successive rises
        miso_bits = 64'h53;
        start(48'h1234_5678_9ABC, 6'd8, 1'b0);
        check_eq("t6_rdata_cleared", rdata, 48'h0);
        run_to_done(1, 50);
        check_eq("t6_rdata_at_done", rdata, 48'h0000_0000_00CA);
        repeat (2) tick();
        check_eq("t6_rdata_held", rdata, 48'h0000_0000_00CA);
        miso_bits = '0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
